maple_frame_deserializer: RTL and testbench

- Downstream stage of the Maple Bus start frame decoder in rxMapleBus.
- Consumes its one-cycle start strobes, the synchronised SDCKA/SDCKB levels and their edge strobes; recovers data bits, packs them MSB-first into bytes and emits them on an AXI-Stream-style byte interface with tlast on the final byte.
- Detects the end-of-frame pattern, checks the optional XOR check byte and flags malformed frames.

---
 rtl/maple_pkg.sv | 12 +
 rtl/maple_byte_skid.sv | 46 ++++
 rtl/maple_frame_deserializer.sv | 131 +++++++++++++
 tb/tb_maple_frame_deserializer.sv | 135 +++++++++++++
 4 files changed

// File: rtl/maple_pkg.sv
// maple_pkg: shared state encoding and sizing constants for the Maple Bus receive path
package maple_pkg;
  typedef enum logic [4:0] {
    IDLE    = 5'b00001,
    PHASE_A = 5'b00010,
    PHASE_B = 5'b00100,
    END1    = 5'b01000,
    END2    = 5'b10000
  } state_t;
  localparam int BYTE_W      = 8;
  localparam int TIMEOUT_DEF = 4096;
endpackage

// File: rtl/maple_byte_skid.sv
// maple_byte_skid: pending byte plus AXI-Stream output register with overflow tracking
module maple_byte_skid import maple_pkg::*; (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic [BYTE_W-1:0] data,
  input  logic              push,
  input  logic              finish,
  input  logic              drop,
  input  logic              m_tready,
  output logic [BYTE_W-1:0] m_tdata,
  output logic              m_tvalid,
  output logic              m_tlast,
  output logic              overflow,
  output logic              last_ok
);
  logic [BYTE_W-1:0] pend;
  logic pend_valid, lost, free, move, load;
  assign free    = !m_tvalid || m_tready;
  assign move    = push && pend_valid;
  assign load    = free && (move || (finish && !lost));
  assign last_ok = free && !lost;
  // pending holds the newest byte so the final one can be tagged tlast at frame end
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      pend       <= '0;
      pend_valid <= 1'b0;
      lost       <= 1'b0;
      overflow   <= 1'b0;
      m_tdata    <= '0;
      m_tvalid   <= 1'b0;
      m_tlast    <= 1'b0;
    end else begin
      pend       <= push ? data : pend;
      pend_valid <= !(finish || drop) && (pend_valid || push);
      lost       <= !(finish || drop) && (lost || (move && !free));
      overflow   <= !free && (move || (finish && !lost));
      if (load) begin
        m_tdata  <= pend;
        m_tlast  <= finish;
        m_tvalid <= 1'b1;
      end else if (m_tready) begin
        m_tvalid <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/maple_frame_deserializer.sv
// maple_frame_deserializer: recovers Maple Bus bits into bytes with end/check/timeout handling
module maple_frame_deserializer import maple_pkg::*; #(
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF,
  parameter int CNT_W          = 13
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              sdcka,
  input  logic              sdckb,
  input  logic              sdcka_posedge,
  input  logic              sdcka_negedge,
  input  logic              sdckb_posedge,
  input  logic              sdckb_negedge,
  input  logic              start_frame,
  input  logic              start_with_crc,
  output logic [BYTE_W-1:0] m_tdata,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic              m_tlast,
  output logic              crc_valid,
  output logic              crc_ok,
  output logic              frame_error,
  output logic              overflow
);
  state_t state, state_n;
  logic [BYTE_W-1:0] sr, acc, new_sr;
  logic [2:0] bitcnt;
  logic [CNT_W-1:0] cnt;
  logic byte_seen, crc_en, a_edge, any_edge, b_neg, timeout;
  logic start, shift_en, shift_bit, abort, done, byte_done, last_ok, finish_ok;
  assign a_edge    = sdcka_posedge || sdcka_negedge;
  assign any_edge  = a_edge || sdckb_posedge || sdckb_negedge;
  assign b_neg     = sdckb_negedge && !a_edge;
  assign timeout   = state != IDLE && cnt == CNT_W'(TIMEOUT_CYCLES - 1);
  assign new_sr    = {sr[BYTE_W-2:0], shift_bit};
  assign byte_done = shift_en && bitcnt == 3'd7;
  assign finish_ok = done && byte_seen && last_ok;
  // next state: A-edges win over a simultaneous B-edge, timeout overrides everything
  always_comb begin
    state_n   = state;
    start     = 1'b0;
    shift_en  = 1'b0;
    shift_bit = 1'b0;
    abort     = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE:
        if (start_frame || start_with_crc) begin
          start   = 1'b1;
          state_n = PHASE_A;
        end
      PHASE_A:
        if (sdcka_negedge) begin
          shift_en  = 1'b1;
          shift_bit = sdckb;
          state_n   = PHASE_B;
        end else if (b_neg) begin
          abort   = bitcnt != 3'd0;
          state_n = bitcnt == 3'd0 ? END1 : IDLE;
        end
      PHASE_B:
        if (b_neg) begin
          shift_en  = 1'b1;
          shift_bit = sdcka;
          state_n   = PHASE_A;
        end
      END1:
        if (sdcka_negedge) begin
          abort   = 1'b1;
          state_n = IDLE;
        end else if (b_neg) begin
          state_n = END2;
        end
      END2:
        if (sdcka_negedge || b_neg) begin
          abort   = 1'b1;
          state_n = IDLE;
        end else if (sdcka_posedge) begin
          done    = 1'b1;
          state_n = IDLE;
        end
      default: state_n = IDLE;
    endcase
    if (timeout) begin
      state_n  = IDLE;
      abort    = 1'b1;
      shift_en = 1'b0;
      done     = 1'b0;
    end
  end
  // frame state, bit packing, check accumulator, idle timer and status strobes
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state       <= IDLE;
      sr          <= '0;
      bitcnt      <= '0;
      byte_seen   <= 1'b0;
      crc_en      <= 1'b0;
      acc         <= '0;
      cnt         <= '0;
      frame_error <= 1'b0;
      crc_valid   <= 1'b0;
      crc_ok      <= 1'b0;
    end else begin
      state       <= state_n;
      sr          <= shift_en ? new_sr : sr;
      bitcnt      <= start ? 3'd0 : bitcnt + 3'(shift_en);
      byte_seen   <= !start && (byte_seen || byte_done);
      crc_en      <= start ? start_with_crc : crc_en;
      acc         <= start ? '0 : byte_done ? acc ^ new_sr : acc;
      cnt         <= (state == IDLE || any_edge) ? '0 : cnt + 1'b1;
      frame_error <= abort || (done && !finish_ok);
      crc_valid   <= finish_ok && crc_en;
      crc_ok      <= finish_ok && crc_en && acc == '0;
    end
  end
  maple_byte_skid u_skid (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .data     (new_sr),
    .push     (byte_done),
    .finish   (done && byte_seen),
    .drop     (abort),
    .m_tready (m_tready),
    .m_tdata  (m_tdata),
    .m_tvalid (m_tvalid),
    .m_tlast  (m_tlast),
    .overflow (overflow),
    .last_ok  (last_ok)
  );
endmodule

// File: tb/tb_maple_frame_deserializer.sv
// tb_maple_frame_deserializer: directed checks of byte recovery, check byte, overflow, abort, timeout, reset
module tb_maple_frame_deserializer;
  logic aclk = 1'b0, aresetn = 1'b0, sdcka = 1'b1, sdckb = 1'b1;
  logic sdcka_posedge = 1'b0, sdcka_negedge = 1'b0, sdckb_posedge = 1'b0, sdckb_negedge = 1'b0;
  logic start_frame = 1'b0, start_with_crc = 1'b0, m_tready = 1'b1;
  logic [7:0] m_tdata;
  logic m_tvalid, m_tlast, crc_valid, crc_ok, frame_error, overflow;
  int total = 0, bad = 0, nrx = 0, n_fe = 0, n_ovf = 0, n_cv = 0;
  int r0, fe0, ov0, cv0, w;
  logic [8:0] rx [64];
  bit ph;
  logic lv, ll, lcv, lco, lfe;
  logic [7:0] ld;
  always #5 aclk = ~aclk;
  maple_frame_deserializer #(.TIMEOUT_CYCLES(4096), .CNT_W(13)) dut (
    .aclk(aclk), .aresetn(aresetn), .sdcka(sdcka), .sdckb(sdckb),
    .sdcka_posedge(sdcka_posedge), .sdcka_negedge(sdcka_negedge),
    .sdckb_posedge(sdckb_posedge), .sdckb_negedge(sdckb_negedge),
    .start_frame(start_frame), .start_with_crc(start_with_crc),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
    .crc_valid(crc_valid), .crc_ok(crc_ok), .frame_error(frame_error), .overflow(overflow)
  );
  // record every accepted byte and count status strobes mid-cycle
  always @(negedge aclk) begin
    if (m_tvalid && m_tready) begin
      rx[nrx % 64] = {m_tlast, m_tdata};
      nrx++;
    end
    n_fe  += int'(frame_error);
    n_ovf += int'(overflow);
    n_cv  += int'(crc_valid);
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge aclk);
      #1;
    end
  endtask
  task automatic mark();
    r0 = nrx; fe0 = n_fe; ov0 = n_ovf; cv0 = n_cv;
  endtask
  task automatic start(input bit crc);
    start_frame = !crc; start_with_crc = crc;
    cyc;
    start_frame = 0; start_with_crc = 0; ph = 0;
    cyc;
  endtask
  task automatic send_bit(input bit b);
    if (!ph) begin sdckb = b; sdcka_negedge = 1; end
    else begin sdcka = b; sdckb_negedge = 1; end
    cyc;
    sdcka_negedge = 0; sdckb_negedge = 0; ph = !ph;
    cyc;
  endtask
  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask
  task automatic end_pat();
    sdckb_negedge = 1; cyc; sdckb_negedge = 0; cyc;
    sdckb_negedge = 1; cyc; sdckb_negedge = 0; cyc;
    sdcka_posedge = 1; cyc; sdcka_posedge = 0;
    lv = m_tvalid; ll = m_tlast; ld = m_tdata; lcv = crc_valid; lco = crc_ok; lfe = frame_error;
    cyc(3);
  endtask
  initial begin
    cyc(2);
    chk("reset_outs", {m_tvalid, m_tlast, m_tdata, crc_valid, crc_ok, frame_error, overflow}, 0);
    aresetn = 1;
    cyc;
    // two plain bytes
    mark(); start(0); send_byte(8'hA5); send_byte(8'h3C); end_pat();
    chk("t1_last_valid", lv, 1); chk("t1_last_tlast", ll, 1); chk("t1_last_data", ld, 8'h3C);
    chk("t1_crc_valid", lcv, 0); chk("t1_nbytes", nrx - r0, 2);
    chk("t1_byte0", rx[r0 % 64], 9'h0A5); chk("t1_byte1", rx[(r0 + 1) % 64], 9'h13C);
    chk("t1_errors", n_fe - fe0, 0); chk("t1_overflow", n_ovf - ov0, 0);
    // check byte good then bad
    mark(); start(1); send_byte(8'h12); send_byte(8'h34); send_byte(8'h26); end_pat();
    chk("t2_crc_valid", lcv, 1); chk("t2_crc_ok", lco, 1); chk("t2_nbytes", nrx - r0, 3);
    chk("t2_last", rx[(r0 + 2) % 64], 9'h126); chk("t2_errors", n_fe - fe0, 0);
    mark(); start(1); send_byte(8'h12); send_byte(8'h34); send_byte(8'h27); end_pat();
    chk("t2b_crc_valid", lcv, 1); chk("t2b_crc_ok", lco, 0); chk("t2b_data", ld, 8'h27);
    chk("t2b_cv_count", n_cv - cv0, 1);
    // sink stalled: overflow and error at end
    m_tready = 0;
    mark(); start(0);
    for (int i = 1; i <= 4; i++) send_byte(8'(i));
    end_pat();
    chk("t3_hold_valid", m_tvalid, 1); chk("t3_hold_data", m_tdata, 8'h01); chk("t3_hold_last", m_tlast, 0);
    chk("t3_overflow", n_ovf - ov0, 2); chk("t3_errors", n_fe - fe0, 1); chk("t3_end_err", lfe, 1);
    chk("t3_crc_valid", n_cv - cv0, 0);
    m_tready = 1; cyc(2);
    chk("t3_nbytes", nrx - r0, 1); chk("t3_byte", rx[r0 % 64], 9'h001);
    // end pattern mid-byte
    mark(); start(0); send_byte(8'hAB);
    for (int i = 0; i < 4; i++) send_bit(i < 2);
    sdckb_negedge = 1; cyc; sdckb_negedge = 0;
    chk("t4_err_strobe", frame_error, 1);
    cyc(3);
    chk("t4_no_valid", m_tvalid, 0); chk("t4_nbytes", nrx - r0, 0); chk("t4_errors", n_fe - fe0, 1);
    // idle timeout then a clean frame
    mark(); start(0);
    for (int i = 0; i < 5; i++) send_bit(i[0]);
    w = 0;
    while (!frame_error && w < 5000) begin
      w++;
      cyc;
    end
    chk("t5_timeout_cycles", w, 4095);
    cyc;
    chk("t5_err_one_cycle", frame_error, 0);
    mark(); start(0); send_byte(8'hFF); end_pat();
    chk("t5_data", ld, 8'hFF); chk("t5_tlast", ll, 1); chk("t5_err", lfe, 0);
    chk("t5_nbytes", nrx - r0, 1);
    // reset mid-byte with a byte held on the output
    m_tready = 0;
    start(0); send_byte(8'h11); send_byte(8'h22);
    for (int i = 0; i < 3; i++) send_bit(1);
    chk("t6_pre_valid", m_tvalid, 1); chk("t6_pre_data", m_tdata, 8'h11);
    aresetn = 0; cyc; aresetn = 1;
    chk("t6_reset_outs", {m_tvalid, m_tlast, m_tdata, crc_valid, crc_ok, frame_error, overflow}, 0);
    m_tready = 1;
    mark(); start(0); send_byte(8'h80); end_pat();
    chk("t6_data", ld, 8'h80); chk("t6_tlast", ll, 1); chk("t6_err", lfe, 0);
    chk("t6_nbytes", nrx - r0, 1); chk("t6_byte", rx[r0 % 64], 9'h180);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
